// File: rtl/spi_sd_master.sv
// Byte-wide mode-0 SPI master for SD cards, driven by a CPU strobe/cmd/data triple.
// Optional SPI_LOOPBACK_EN: the receive shifter samples internal mosi instead of spi_miso.
module spi_sd_master #(
   parameter int DIV_FAST  = 2,
   parameter int DIV_INIT  = 64,
   parameter int INIT_CLKS = 80
) (
   input  logic       clk50,
   input  logic       reset,
   output logic       spi_cs,
   output logic       spi_sclk,
   input  logic       spi_miso,
   output logic       spi_mosi,
   input  logic       spi_sent,
   input  logic [1:0] spi_cmd,
   input  logic [7:0] spi_din,
   output logic [7:0] spi_out,
   output logic [1:0] spi_st
);

   localparam int DMAX = (DIV_INIT > DIV_FAST) ? DIV_INIT : DIV_FAST;
   localparam int DW   = $clog2(DMAX + 1);
   localparam int CMAX = (INIT_CLKS > 8) ? INIT_CLKS : 8;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] XFER = 2'd1;
   localparam logic [1:0] INIT = 2'd2;

   logic [1:0]    state;
   logic          sent_q;
   logic          sent_prev;
   logic          init_done;
   logic [DW-1:0] div_cnt;
   logic [DW-1:0] div_last;
   logic [CW-1:0] bit_cnt;
   logic [CW-1:0] bit_last;
   logic [7:0]    tx_sh;
   logic [7:0]    rx_sh;
   logic          rx_bit;
   logic          accept;
   logic          half_end;
   logic          is_xfer;

`ifdef SPI_LOOPBACK_EN
   assign rx_bit = spi_mosi;
`else
   assign rx_bit = spi_miso;
`endif

   assign is_xfer  = (state == XFER);
   assign accept   = sent_q & ~sent_prev & (state == IDLE);
   assign div_last = is_xfer ? DW'(DIV_FAST - 1) : DW'(DIV_INIT - 1);
   assign bit_last = is_xfer ? CW'(7) : CW'(INIT_CLKS - 1);
   assign half_end = (div_cnt == div_last);
   assign spi_st   = {init_done, state != IDLE};

   always_ff @(posedge clk50) begin
      if (reset) begin
         state     <= IDLE;
         spi_cs    <= 1'b1;
         spi_sclk  <= 1'b0;
         spi_mosi  <= 1'b1;
         spi_out   <= 8'hFF;
         init_done <= 1'b0;
         sent_q    <= 1'b0;
         sent_prev <= 1'b0;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         tx_sh     <= '0;
         rx_sh     <= '0;
      end else begin
         sent_q    <= spi_sent;
         sent_prev <= sent_q;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  div_cnt  <= '0;
                  bit_cnt  <= '0;
                  spi_sclk <= 1'b0;
                  unique case (spi_cmd)
                     2'd0: begin
                        state    <= XFER;
                        tx_sh    <= spi_din;
                        spi_mosi <= spi_din[7];
                     end
                     2'd1: begin
                        state    <= INIT;
                        spi_cs   <= 1'b1;
                        spi_mosi <= 1'b1;
                     end
                     2'd2: spi_cs <= 1'b0;
                     2'd3: spi_cs <= 1'b1;
                  endcase
               end
            end
            XFER, INIT: begin
               if (!half_end) begin
                  div_cnt <= div_cnt + 1'b1;
               end else begin
                  div_cnt  <= '0;
                  spi_sclk <= ~spi_sclk;
                  if (!spi_sclk) begin
                     if (is_xfer)
                        rx_sh <= {rx_sh[6:0], rx_bit};
                  end else if (bit_cnt == bit_last) begin
                     // Last falling edge: publish result and release the bus.
                     state    <= IDLE;
                     spi_mosi <= 1'b1;
                     if (is_xfer)
                        spi_out <= rx_sh;
                     else
                        init_done <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     if (is_xfer) begin
                        tx_sh    <= {tx_sh[6:0], 1'b0};
                        spi_mosi <= tx_sh[6];
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_sd_master.sv
// Self-checking bench for spi_sd_master: timeline model checked every cycle
// plus hand-computed literal checks.
module tb_spi_sd_master;

   logic       clk50 = 1'b0;
   logic       reset;
   logic       spi_cs;
   logic       spi_sclk;
   logic       spi_miso = 1'b1;
   logic       spi_mosi;
   logic       spi_sent;
   logic [1:0] spi_cmd;
   logic [7:0] spi_din;
   logic [7:0] spi_out;
   logic [1:0] spi_st;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   // model: committed state plus one pending command
   bit         pend;
   int         m_kind;
   int         m_start;
   logic [7:0] m_din;
   logic [7:0] m_mrx;
   logic [7:0] m_out;
   logic       m_cs;
   logic       m_done;

   int         redges = 0;
   logic [7:0] mcap = 8'h00;

   spi_sd_master dut (
      .clk50    (clk50),
      .reset    (reset),
      .spi_cs   (spi_cs),
      .spi_sclk (spi_sclk),
      .spi_miso (spi_miso),
      .spi_mosi (spi_mosi),
      .spi_sent (spi_sent),
      .spi_cmd  (spi_cmd),
      .spi_din  (spi_din),
      .spi_out  (spi_out),
      .spi_st   (spi_st)
   );

   always #5 clk50 = ~clk50;

   always @(posedge clk50) cyc <= cyc + 1;

   always @(posedge spi_sclk) begin
      redges <= redges + 1;
      mcap   <= {mcap[6:0], spi_mosi};
   end

   function automatic logic [7:0] rx_exp();
`ifdef SPI_LOOPBACK_EN
      return m_din;
`else
      return m_mrx;
`endif
   endfunction

   function automatic int cmd_len(input int k);
      if (k == 0) return 32;
      if (k == 1) return 80 * 2 * 64;
      return 1;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at cyc %0d", name, act, exp, cyc);
      end
   endtask

   // card side: present bit b of m_mrx around the b-th rising SCLK
   always @(posedge clk50) begin
      #1;
      if (pend && m_kind == 0 && cyc + 1 >= m_start
          && (cyc + 1 - m_start) / 4 < 8)
         spi_miso = m_mrx[7 - (cyc + 1 - m_start) / 4];
      else
         spi_miso = 1'b1;
   end

   always @(negedge clk50) begin : cmp
      int t;
      int h;
      logic e_cs, e_sclk, e_mosi, e_busy, e_done;
      logic [7:0] e_out;
      if (chk_en) begin
         e_cs = m_cs;
         e_sclk = 1'b0;
         e_mosi = 1'b1;
         e_busy = 1'b0;
         e_done = m_done;
         e_out = m_out;
         if (pend && cyc >= m_start) begin
            t = cyc - m_start;
            case (m_kind)
               0: begin
                  if (t < 32) begin
                     h = t / 2;
                     e_busy = 1'b1;
                     e_sclk = h[0];
                     e_mosi = m_din[7 - h / 2];
                  end else begin
                     e_out = rx_exp();
                  end
               end
               1: begin
                  e_cs = 1'b1;
                  if (t < cmd_len(1)) begin
                     e_busy = 1'b1;
                     e_sclk = ((t / 64) % 2) == 1;
                  end else begin
                     e_done = 1'b1;
                  end
               end
               2: e_cs = 1'b0;
               default: e_cs = 1'b1;
            endcase
         end
         check("cs", spi_cs, e_cs);
         check("sclk", spi_sclk, e_sclk);
         check("mosi", spi_mosi, e_mosi);
         check("out", spi_out, e_out);
         check("st", spi_st, {e_done, e_busy});
      end
   end

   task automatic tick();
      @(posedge clk50);
      #2;
   endtask

   task automatic commit();
      if (pend) begin
         case (m_kind)
            0: m_out = rx_exp();
            1: begin
               m_done = 1'b1;
               m_cs = 1'b1;
            end
            2: m_cs = 1'b0;
            default: m_cs = 1'b1;
         endcase
         pend = 1'b0;
      end
   endtask

   task automatic issue(input int k, input logic [7:0] d, input logic [7:0] r);
      commit();
      spi_cmd  = 2'(k);
      spi_din  = d;
      spi_sent = 1'b1;
      m_kind   = k;
      m_din    = d;
      m_mrx    = r;
      m_start  = cyc + 2;
      pend     = 1'b1;
   endtask

   // strobe held high for the whole command, then released
   task automatic run(input int k, input logic [7:0] d, input logic [7:0] r);
      issue(k, d, r);
      repeat (cmd_len(k) + 3) tick();
      spi_sent = 1'b0;
      tick();
      tick();
   endtask

   int r0;

   initial begin
      reset = 1'b1;
      spi_sent = 1'b0;
      spi_cmd = 2'd0;
      spi_din = 8'h00;
      pend = 1'b0;
      m_kind = 0;
      m_start = 0;
      m_din = 8'h00;
      m_mrx = 8'hFF;
      m_cs = 1'b1;
      m_out = 8'hFF;
      m_done = 1'b0;
      repeat (3) tick();
      check("rst_cs", spi_cs, 1);
      check("rst_sclk", spi_sclk, 0);
      check("rst_mosi", spi_mosi, 1);
      check("rst_out", spi_out, 8'hFF);
      check("rst_st", spi_st, 0);
      reset = 1'b0;
      chk_en = 1'b1;
      tick();

      // exchange A5 with miso held high
      run(0, 8'hA5, 8'hFF);
      check("a5_mosi_bits", mcap, 8'hA5);
`ifdef SPI_LOOPBACK_EN
      check("a5_out", spi_out, 8'hA5);
`else
      check("a5_out", spi_out, 8'hFF);
`endif
      check("a5_st", spi_st, 0);

      run(0, 8'h3C, 8'h5A);
`ifdef SPI_LOOPBACK_EN
      check("3c_out", spi_out, 8'h3C);
`else
      check("3c_out", spi_out, 8'h5A);
`endif

      run(2, 8'h00, 8'h00);
      check("cs_low", spi_cs, 0);
      run(3, 8'h00, 8'h00);
      check("cs_high", spi_cs, 1);

      r0 = redges;
      run(1, 8'h00, 8'h00);
      check("init_edges", redges - r0, 80);
      check("init_st", spi_st, 2'b10);

      // strobe edge in the middle of an exchange is dropped
      run(2, 8'h00, 8'h00);
      r0 = redges;
      issue(0, 8'h96, 8'hC3);
      tick();
      spi_sent = 1'b0;
      repeat (8) tick();
      spi_sent = 1'b1;
      spi_cmd = 2'd3;
      repeat (30) tick();
      spi_sent = 1'b0;
      tick();
      tick();
      check("busy_edges", redges - r0, 8);
      check("busy_cs", spi_cs, 0);
`ifdef SPI_LOOPBACK_EN
      check("96_out", spi_out, 8'h96);
`else
      check("96_out", spi_out, 8'hC3);
`endif

      // strobe edge seen on the completion cycle is dropped
      issue(0, 8'h81, 8'h7E);
      tick();
      spi_sent = 1'b0;
      while (cyc < m_start + 30) tick();
      spi_sent = 1'b1;
      spi_cmd = 2'd3;
      repeat (6) tick();
      spi_sent = 1'b0;
      tick();
      check("done_cs", spi_cs, 0);
`ifdef SPI_LOOPBACK_EN
      check("81_out", spi_out, 8'h81);
`else
      check("81_out", spi_out, 8'h7E);
`endif

      run(1, 8'h00, 8'h00);
      check("init2_st", spi_st, 2'b10);
      check("init2_cs", spi_cs, 1);

      // reset after the third SCLK rising edge
      run(2, 8'h00, 8'h00);
      issue(0, 8'hF0, 8'h0F);
      while (cyc < m_start + 10) tick();
      check("pre_rst_sclk", spi_sclk, 1);
      chk_en = 1'b0;
      reset = 1'b1;
      spi_sent = 1'b0;
      tick();
      check("ab_sclk", spi_sclk, 0);
      check("ab_cs", spi_cs, 1);
      check("ab_mosi", spi_mosi, 1);
      check("ab_out", spi_out, 8'hFF);
      check("ab_st", spi_st, 0);
      pend = 1'b0;
      m_cs = 1'b1;
      m_out = 8'hFF;
      m_done = 1'b0;
      reset = 1'b0;
      tick();
      chk_en = 1'b1;
      repeat (5) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
